correlator_xor_search: RTL and testbench
========================================

Name: correlator_xor_search

Overview:
Parametrised next-generation binary-frame XOR correlator for the motion-stabilisation datapath. It reads a reference frame and a current frame, one row per BRAM word, from a single-read-port BRAM. It computes the Hamming-distance correlation of a fixed reference window against a displaced current window. A new search mode sweeps a rectangle of displacements and reports the minimum sum and its offset.

Parameters:
DATA_W, 128, BRAM word width; one frame row, bit c = pixel column c
ADDR_W, 9, BRAM address width
FRAME_WORDS, 128, word offset of frame 1 (frame 0 base = 0)
MARGIN, 32, reference window origin (row and column); zero-motion offset
WIN_W, 64, window width in pixels
WIN_H, 64, window height in rows
OFF_W, 6, offset width; legal offsets 0..2^OFF_W-1
SUM_W, 16, sum width; must satisfy 2^SUM_W > WIN_W*WIN_H

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
go  in  1  start pulse; sampled only in IDLE
mode  in  1  0 = single offset, 1 = search sweep
x_offset  in  OFF_W  single-mode x offset / sweep x origin
y_offset  in  OFF_W  single-mode y offset / sweep y origin
span  in  OFF_W  sweep extent; x,y each cover origin..origin+span
curr_frame_sel  in  1  0: current=frame0, reference=frame1; 1: swapped
bram_addr  out  ADDR_W  read address
bram_data  in  DATA_W  read data, valid 1 cycle after address
corr_sum  out  SUM_W  sum of most recently finished offset
best_sum  out  SUM_W  minimum sum found (search); equals corr_sum in single mode
best_x  out  OFF_W  x of best_sum
best_y  out  OFF_W  y of best_sum
busy  out  1  high from go acceptance until done
done  out  1  one-cycle pulse at end of operation

Behaviour:
- Reset (async, any state): IDLE; bram_addr=0, corr_sum=0, best_sum=all ones, best_x=best_y=0, busy=0, done=0. Pipeline and accumulators cleared. No done is produced for an aborted operation.
- go, mode, offsets, span and curr_frame_sel are latched on the go-accept edge. Later input changes are ignored. go while busy is ignored.
- Per-offset correlation:
  - S(x,y) = sum over r in 0..WIN_H-1, c in 0..WIN_W-1 of ref[MARGIN+r][MARGIN+c] XOR cur[y+r][x+c].
  - Legal iff x+WIN_W <= DATA_W and y+WIN_H <= FRAME_WORDS. Defaults: all 0..63 are legal.
- Read sequencing:
  - Each row issues two consecutive reads, reference row then current row, one address per cycle. The first address is in the cycle after go acceptance.
  - Pipeline stages:
    - data capture
    - window extract + XOR + popcount, registered
    - accumulate
  - Offsets in a sweep are back-to-back with no bubble cycles.
- Latency: single mode, done is high exactly 2*WIN_H+3 cycles after the go-accept edge (131 at defaults). busy falls in the same cycle done rises.
- FSM states:
  - IDLE -(go)-> RUN
  - RUN -(last read issued)-> DRAIN
  - DRAIN -(last accumulate)-> FINISH (done=1)
  - FINISH -> IDLE
- Sweep order: y outer, x inner, both ascending from origin.
  - Each axis stops at origin+span, or at 2^OFF_W-1 if that is smaller. There is no wrap-around.
  - Number of offsets = (nx)*(ny). Search latency = nx*ny*2*WIN_H+3.
- Best tracking:
  - Update only when S < best_sum (strict), so ties keep the first in raster order.
  - best_sum is reset to all ones at each go.
  - corr_sum updates at every offset completion.
- Outputs hold until the next go or reset.

Test Plan:
- Both frames all zero, mode=0, x=y=32 -> done at cycle 131, corr_sum=0, best_x=best_y=32.
- Reference frame all zero, current frame all ones, mode=0 -> corr_sum=4096 (0x1000).
- Current frame = reference frame shifted right 3 columns and down 2 rows (random pattern):
  - mode=0 at x=35, y=34 -> corr_sum=0.
  - mode=1, origin 30/30, span 7 -> best_x=35, best_y=34, best_sum=0, done after 64*128+3 cycles.
- Sweep clipping: origin 60/60, span 10 -> 16 offsets (x,y 60..63), done after 16*128+3 cycles; the address trace never references row >127.
- go pulsed again mid-run with different offsets -> ignored; results match the first request. curr_frame_sel=1 -> address bases swap (reference reads from 0..127, current from 128..255).
- reset asserted at cycle 50 of a run -> all outputs at reset values in the same cycle, no done. A subsequent go completes normally.

Source files
------------

// File: rtl/correlator_xor_search.sv
// correlator_xor_search
//   Binary-frame XOR correlator. For each offset (x,y) it computes the
//   Hamming distance between a fixed reference window at (MARGIN,MARGIN)
//   and a current-frame window at (x,y). Both frames live in a single-port
//   BRAM, one frame row per word. In search mode it sweeps a rectangle of
//   offsets and keeps the minimum sum and the offset where it occurred.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   go              start pulse, sampled only in IDLE
//   mode            0 = single offset, 1 = search sweep
//   x_offset/y_offset  single offset, or sweep origin
//   span            sweep extent per axis (origin..origin+span, clipped)
//   curr_frame_sel  0: current=frame0, reference=frame1; 1: swapped
//   bram_addr/bram_data  read port, data valid one cycle after address
//   corr_sum        sum of the most recently finished offset
//   best_sum/best_x/best_y  minimum sum and its offset
//   busy, done      busy from go acceptance to done; done is a 1-cycle pulse
module correlator_xor_search #(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 9,
   parameter int FRAME_WORDS = 128,
   parameter int MARGIN      = 32,
   parameter int WIN_W       = 64,
   parameter int WIN_H       = 64,
   parameter int OFF_W       = 6,
   parameter int SUM_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              mode,
   input  logic [OFF_W-1:0]  x_offset,
   input  logic [OFF_W-1:0]  y_offset,
   input  logic [OFF_W-1:0]  span,
   input  logic              curr_frame_sel,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_data,
   output logic [SUM_W-1:0]  corr_sum,
   output logic [SUM_W-1:0]  best_sum,
   output logic [OFF_W-1:0]  best_x,
   output logic [OFF_W-1:0]  best_y,
   output logic              busy,
   output logic              done
);
   localparam int ROW_W  = (WIN_H > 1) ? $clog2(WIN_H) : 1;
   localparam int STAGES = 3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   // Travels with each read through the pipeline.
   typedef struct packed {
      logic             cur;       // 1 = current-frame row, 0 = reference row
      logic             last_row;  // last row of this offset
      logic             last_all;  // last row of the whole operation
      logic [OFF_W-1:0] x;
      logic [OFF_W-1:0] y;
   } tag_t;

   state_t state_q, state_d;

   // latched request
   logic             sel_q;
   logic [OFF_W-1:0] x0_q, xend_q, yend_q;
   // read sequencer: describes the read currently on bram_addr
   logic             ph_q;
   logic [ROW_W-1:0] row_q;
   logic [OFF_W-1:0] ox_q, oy_q;

   logic [STAGES:0]  vld_pipe;
   tag_t             tag0, tag1, tag2, tag3;
   logic [DATA_W-1:0] ref_q, cur_q;
   logic [SUM_W-1:0] pop_q, acc_q;

   function automatic logic [ADDR_W-1:0] ref_addr(input logic sel, input logic [ROW_W-1:0] r);
      return (sel ? ADDR_W'(0) : ADDR_W'(FRAME_WORDS)) + ADDR_W'(MARGIN) + ADDR_W'(r);
   endfunction

   function automatic logic [ADDR_W-1:0] cur_addr(input logic sel, input logic [OFF_W-1:0] y,
                                                  input logic [ROW_W-1:0] r);
      return (sel ? ADDR_W'(FRAME_WORDS) : ADDR_W'(0)) + ADDR_W'(y) + ADDR_W'(r);
   endfunction

   function automatic logic [SUM_W-1:0] popcount(input logic [WIN_W-1:0] v);
      logic [SUM_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIN_W; i++) n = n + SUM_W'(v[i]);
      return n;
   endfunction

   // sweep end per axis, clipped at the top of the offset range (no wrap)
   logic [OFF_W:0]   xsum, ysum;
   logic [OFF_W-1:0] x_end, y_end;
   always_comb begin
      xsum  = {1'b0, x_offset} + {1'b0, (mode ? span : {OFF_W{1'b0}})};
      ysum  = {1'b0, y_offset} + {1'b0, (mode ? span : {OFF_W{1'b0}})};
      x_end = xsum[OFF_W] ? {OFF_W{1'b1}} : xsum[OFF_W-1:0];
      y_end = ysum[OFF_W] ? {OFF_W{1'b1}} : ysum[OFF_W-1:0];
   end

   // next read after the one on the bus: ref -> cur same row -> ref next row ...
   logic             last_row, all_last, go_acc, run_adv;
   logic             n_ph;
   logic [ROW_W-1:0] n_row;
   logic [OFF_W-1:0] n_ox, n_oy;
   always_comb begin
      last_row = (row_q == ROW_W'(WIN_H-1));
      all_last = ph_q && last_row && (ox_q == xend_q) && (oy_q == yend_q);
      n_ph  = ~ph_q;
      n_row = row_q;
      n_ox  = ox_q;
      n_oy  = oy_q;
      if (ph_q) begin
         if (last_row) begin
            n_row = '0;
            if (ox_q == xend_q) begin
               n_ox = x0_q;
               n_oy = oy_q + 1'b1;
            end else begin
               n_ox = ox_q + 1'b1;
            end
         end else begin
            n_row = row_q + 1'b1;
         end
      end
      go_acc  = (state_q == IDLE) && go;
      run_adv = (state_q == RUN) && !all_last;
   end

   // window extract + XOR
   logic [DATA_W-1:0] cur_sh;
   logic [WIN_W-1:0]  diff;
   always_comb begin
      cur_sh = cur_q >> tag2.x;
      diff   = ref_q[MARGIN +: WIN_W] ^ cur_sh[WIN_W-1:0];
   end

   logic [SUM_W-1:0] acc_sum;
   logic             acc_fin;
   always_comb begin
      acc_sum = acc_q + pop_q;
      acc_fin = vld_pipe[3] && tag3.last_all;
   end

   // FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:   if (go) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (all_last) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (acc_fin) state_d = FINISH;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // sequencer + datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q     <= 1'b0;
         x0_q      <= '0;
         xend_q    <= '0;
         yend_q    <= '0;
         ph_q      <= 1'b0;
         row_q     <= '0;
         ox_q      <= '0;
         oy_q      <= '0;
         bram_addr <= '0;
         vld_pipe  <= '0;
         tag0      <= '0;
         tag1      <= '0;
         tag2      <= '0;
         tag3      <= '0;
         ref_q     <= '0;
         cur_q     <= '0;
         pop_q     <= '0;
         acc_q     <= '0;
         corr_sum  <= '0;
         best_sum  <= '1;
         best_x    <= '0;
         best_y    <= '0;
      end else begin
         vld_pipe[0] <= go_acc || run_adv;
         if (go_acc) begin
            // the first reference read goes out on the accept edge itself
            sel_q     <= curr_frame_sel;
            x0_q      <= x_offset;
            xend_q    <= x_end;
            yend_q    <= y_end;
            ph_q      <= 1'b0;
            row_q     <= '0;
            ox_q      <= x_offset;
            oy_q      <= y_offset;
            bram_addr <= ref_addr(curr_frame_sel, '0);
            tag0      <= '{cur: 1'b0, last_row: 1'b0, last_all: 1'b0, x: x_offset, y: y_offset};
            best_sum  <= '1;
         end else if (run_adv) begin
            ph_q      <= n_ph;
            row_q     <= n_row;
            ox_q      <= n_ox;
            oy_q      <= n_oy;
            bram_addr <= n_ph ? cur_addr(sel_q, n_oy, n_row) : ref_addr(sel_q, n_row);
            tag0      <= '{cur: n_ph, last_row: (n_row == ROW_W'(WIN_H-1)),
                           last_all: n_ph && (n_row == ROW_W'(WIN_H-1)) && (n_ox == xend_q) && (n_oy == yend_q),
                           x: n_ox, y: n_oy};
         end

         // data on the bus
         vld_pipe[1] <= vld_pipe[0];
         tag1        <= tag0;

         // capture; a pair completes when its current row arrives
         if (vld_pipe[1]) begin
            if (tag1.cur) cur_q <= bram_data;
            else          ref_q <= bram_data;
         end
         vld_pipe[2] <= vld_pipe[1] && tag1.cur;
         tag2        <= tag1;

         // XOR + popcount
         vld_pipe[3] <= vld_pipe[2];
         tag3        <= tag2;
         pop_q       <= popcount(diff);

         // accumulate; offsets follow each other without a bubble
         if (vld_pipe[3]) begin
            if (tag3.last_row) begin
               acc_q    <= '0;
               corr_sum <= acc_sum;
               if (acc_sum < best_sum && !go_acc) begin
                  best_sum <= acc_sum;
                  best_x   <= tag3.x;
                  best_y   <= tag3.y;
               end
            end else begin
               acc_q <= acc_sum;
            end
         end
      end
   end
endmodule

// File: tb/tb_correlator_xor_search.sv
// Scoreboard bench for correlator_xor_search: each run pushes its
// hand-computed expectation; a monitor pops and compares on every done.
module tb_correlator_xor_search;
   localparam int DATA_W = 128, ADDR_W = 9, FW = 128, MARGIN = 32;
   localparam int OFF_W = 6, SUM_W = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              go = 1'b0, mode = 1'b0, curr_frame_sel = 1'b0;
   logic [OFF_W-1:0]  x_offset = '0, y_offset = '0, span = '0;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_data = '0;
   logic [SUM_W-1:0]  corr_sum, best_sum;
   logic [OFF_W-1:0]  best_x, best_y;
   logic              busy, done;

   correlator_xor_search dut (
      .clk(clk), .reset(reset), .go(go), .mode(mode),
      .x_offset(x_offset), .y_offset(y_offset), .span(span),
      .curr_frame_sel(curr_frame_sel), .bram_addr(bram_addr), .bram_data(bram_data),
      .corr_sum(corr_sum), .best_sum(best_sum), .best_x(best_x), .best_y(best_y),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [0:511];
   always @(posedge clk) bram_data <= mem[bram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [SUM_W-1:0] corr, best;
      logic [OFF_W-1:0] bx, by;
      int               lat;
      bit               chk_corr;
      int               go_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0, n_total = 0, n_done = 0;
   int   max_cur = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // highest current-frame row address read (frame 0 = current when sel=0)
   always @(negedge clk) if (busy && bram_addr < ADDR_W'(FW) && int'(bram_addr) > max_cur) max_cur = int'(bram_addr);

   // monitor
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            if (e.chk_corr) chk("corr_sum", corr_sum, e.corr);
            chk("best_sum", best_sum, e.best);
            chk("best_x", best_x, e.bx);
            chk("best_y", best_y, e.by);
            chk("latency", cyc - e.go_cyc, e.lat);
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end

   logic [DATA_W-1:0] pat [0:FW-1];

   function automatic logic [DATA_W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // kind 0: zeros; 1: ref zero, cur ones; 2: cur = ref shifted right 3, down 2
   task automatic fill(input int kind, input logic sel);
      int rb, cb;
      rb = sel ? 0 : FW;
      cb = sel ? FW : 0;
      for (int r = 0; r < FW; r++) begin
         case (kind)
            0: begin mem[rb+r] = '0; mem[cb+r] = '0; end
            1: begin mem[rb+r] = '0; mem[cb+r] = '1; end
            default: begin
               mem[rb+r] = pat[r];
               mem[cb+r] = (r >= 2) ? (pat[r-2] << 3) : rnd();
            end
         endcase
      end
   endtask

   task automatic start(input logic m, input int x, input int y, input int sp, input logic sel,
                        input logic push, input exp_t e);
      @(negedge clk);
      mode = m; x_offset = OFF_W'(x); y_offset = OFF_W'(y); span = OFF_W'(sp);
      curr_frame_sel = sel; go = 1'b1;
      max_cur = 0;
      @(posedge clk);
      #1;
      go = 1'b0;
      e.go_cyc = cyc;
      if (push) sb.push_back(e);
      chk("first_addr", bram_addr, sel ? ADDR_W'(MARGIN) : ADDR_W'(FW + MARGIN));
      // request inputs must be latched; scramble them
      x_offset = OFF_W'($urandom); y_offset = OFF_W'($urandom); span = OFF_W'($urandom);
      mode = ~m;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         chk("timeout", 32'd1, 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   function automatic exp_t mk(input int corr, input int best, input int bx, input int by,
                               input int lat, input bit cc);
      exp_t e;
      e.corr = SUM_W'(corr); e.best = SUM_W'(best);
      e.bx = OFF_W'(bx); e.by = OFF_W'(by);
      e.lat = lat; e.chk_corr = cc; e.go_cyc = 0;
      return e;
   endfunction

   initial begin
      int d0;
      for (int i = 0; i < 512; i++) mem[i] = '0;
      for (int r = 0; r < FW; r++) pat[r] = rnd();
      repeat (3) @(negedge clk);
      chk("rst_addr", bram_addr, '0);
      chk("rst_corr", corr_sum, '0);
      chk("rst_best", best_sum, 16'hffff);
      chk("rst_bxy", {best_x, best_y}, '0);
      chk("rst_busy_done", {busy, done}, 2'b00);
      reset = 1'b0;
      @(negedge clk);

      // all zero, single
      fill(0, 1'b0);
      start(1'b0, 32, 32, 0, 1'b0, 1'b1, mk(0, 0, 32, 32, 131, 1));
      wait_done(400);

      // ref zero, cur ones
      fill(1, 1'b0);
      start(1'b0, 32, 32, 0, 1'b0, 1'b1, mk(4096, 4096, 32, 32, 131, 1));
      wait_done(400);

      // shifted pattern, single at the matching offset
      fill(2, 1'b0);
      start(1'b0, 35, 34, 0, 1'b0, 1'b1, mk(0, 0, 35, 34, 131, 1));
      wait_done(400);

      // sweep 30..37 x 30..37
      start(1'b1, 30, 30, 7, 1'b0, 1'b1, mk(0, 0, 35, 34, 64*128+3, 0));
      wait_done(9000);

      // clipped sweep 60..63; every offset ties at 4096, first one wins
      fill(1, 1'b0);
      start(1'b1, 60, 60, 10, 1'b0, 1'b1, mk(4096, 4096, 60, 60, 16*128+3, 1));
      wait_done(3000);
      chk("max_cur_row", max_cur, 126);

      // second go mid-run must be ignored
      fill(2, 1'b0);
      start(1'b0, 35, 34, 0, 1'b0, 1'b1, mk(0, 0, 35, 34, 131, 1));
      repeat (20) @(negedge clk);
      mode = 1'b1; x_offset = '0; y_offset = '0; span = 6'd3; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done(400);

      // swapped frames
      fill(2, 1'b1);
      start(1'b0, 35, 34, 0, 1'b1, 1'b1, mk(0, 0, 35, 34, 131, 1));
      wait_done(400);

      // abort with reset at cycle 50
      fill(2, 1'b0);
      start(1'b0, 35, 34, 0, 1'b0, 1'b0, mk(0, 0, 35, 34, 131, 1));
      repeat (49) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_addr", bram_addr, '0);
      chk("abort_corr", corr_sum, '0);
      chk("abort_best", best_sum, 16'hffff);
      chk("abort_bxy", {best_x, best_y}, '0);
      chk("abort_busy_done", {busy, done}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      d0 = n_done;
      repeat (200) @(negedge clk);
      chk("abort_no_done", n_done - d0, 0);

      // normal run after abort
      start(1'b0, 35, 34, 0, 1'b0, 1'b1, mk(0, 0, 35, 34, 131, 1));
      wait_done(400);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
